comp4_sort_ctrl: RTL and testbench
==================================

# comp4_sort_ctrl

Sequencing controller that shares a single `comp4bit` magnitude comparator to bubble-sort a small batch of 4-bit words. Words stream in over a valid/ready port, are held in an internal register file, sorted one comparison per clock through the shared comparator, then streamed out in order over a second valid/ready port. It is the first block that turns the combinational comparator into a scheduled, multi-cycle resource.

## Interface
- `DEPTH`, 4: words per batch; legal 2..8.
- `ASCEND`, 1: 1 = ascending output (swap on `gt`); 0 = descending output (swap on `lt`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  4  word to load; ignored (may be X) unless `in_valid`.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts a word this cycle.
- `out_data`  out  4  sorted word; 0 when `out_valid`=0.
- `out_last`  out  1  high with the final (DEPTH-th) output word.
- `busy`  out  1  high while in SORT.
- `swap_cnt`  out  6  swaps performed in the current/last batch.

## Operation
- The block contains exactly one `comp4bit` instance. Its `x` is `mem[idx]` and its `y` is `mem[idx+1]`. Its `gt`/`eq`/`lt` outputs are the only source of ordering decisions.
- FSM states: LOAD, SORT, DRAIN.
- LOAD:
  - `in_ready`=1.
  - Each transfer (`in_valid`&&`in_ready`) writes `mem[wr_idx]` and increments `wr_idx`.
  - The first transfer of a batch clears `swap_cnt`.
  - On the DEPTH-th transfer: `wr_idx`←0, `idx`←0, `pass`←0, `pass_swapped`←0, go to SORT.
- SORT:
  - One compare per cycle at `idx` (0..DEPTH-2).
  - Swap condition: `gt` when ASCEND=1, `lt` when ASCEND=0. When the condition holds, `mem[idx]` and `mem[idx+1]` exchange, `swap_cnt`+1 and `pass_swapped`←1.
  - `eq` never swaps, so the sort is stable.
  - If `idx`≠DEPTH-2: `idx`+1.
  - If `idx`=DEPTH-2 (end of pass): if no swap occurred in the pass (including the current cycle), or `pass`=DEPTH-2 (DEPTH-1 passes done), go to DRAIN. Otherwise `pass`+1, `idx`←0, `pass_swapped`←0.
- DRAIN:
  - `out_valid`=1, `out_data`=`mem[rd_idx]`, `out_last`=(`rd_idx`=DEPTH-1).
  - Each transfer increments `rd_idx`. After the DEPTH-th transfer, `rd_idx`←0 and the FSM goes to LOAD.
- Width rules: every 4-bit value is unsigned. `swap_cnt` saturates at its maximum, which is unreachable for DEPTH≤8 (max 28).

## Timing
- Reset values: state LOAD, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `swap_cnt`=0, all `mem`=0, all indices 0.
- Reset mid-operation: the partial batch is discarded and the block returns to the reset state immediately, with no pending output.
- Load throughput: 1 word/cycle.
- Entry to SORT: `in_ready` drops and `busy` rises in the cycle after the DEPTH-th input transfer.
- SORT duration: (DEPTH-1)×passes cycles.
  - Sorted input: 1 pass, DEPTH-1 cycles.
  - Worst case: (DEPTH-1)² cycles, i.e. 9 cycles for DEPTH=4.
- Entry to DRAIN: `busy` falls and `out_valid` rises in the cycle after the final compare, with `out_data`=`mem[0]` already swapped.
- Backpressure: while `out_ready`=0 in DRAIN, `out_data` and `out_last` hold stable. `in_valid` gaps in LOAD simply stall.
- Return to LOAD: `in_ready` returns to 1 in the cycle after the last output transfer. Input and output transfers never overlap.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs take their reset values at once; `in_ready`=1 after release.
- Mixed batch (DEPTH=4, ASCEND=1): load 3,1,7,0 back-to-back → `busy` for 9 cycles, `swap_cnt`=4, output 0,1,3,7 with `out_last` only on 7.
- Sorted with tie: load 3,3,7,15 → `busy` for exactly 3 cycles, `swap_cnt`=0, output 3,3,7,15.
- Reverse order, both polarities: load 15,7,3,1 with ASCEND=1 → 9 busy cycles, `swap_cnt`=6, output 1,3,7,15. Same load with ASCEND=0 → 3 busy cycles, `swap_cnt`=0, output 15,7,3,1.
- Handshake stress: X on `in_data` while `in_valid`=0, random `in_valid` gaps, random `out_ready` stalls → X words never stored, `out_data` stable while stalled, exactly DEPTH words out per batch, `in_ready`=0 throughout SORT and DRAIN.
- Reset mid-SORT: load 15,7,3,1, pulse `rst` on the 4th busy cycle, then load 2,0,1,3 → only 0,1,2,3 is emitted, `swap_cnt`=2.

Source files
------------

// File: rtl/comp4_sort_ctrl_if.sv
// Valid/ready load and drain ports of the shared-comparator sorter.
interface comp4_sort_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/comp4_sort_ctrl.sv
// Batch bubble sorter: loads DEPTH 4-bit words, sorts them one compare per clock
// through a single shared comp4bit, then streams them out in order.

module comp4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  logic [3:0] bit_eq;

  assign bit_eq = ~(x ^ y);

  // MSB-first cascade: a bit decides only when every higher bit is equal.
  assign gt = (x[3] & ~y[3])
            | (bit_eq[3] & x[2] & ~y[2])
            | (bit_eq[3] & bit_eq[2] & x[1] & ~y[1])
            | (bit_eq[3] & bit_eq[2] & bit_eq[1] & x[0] & ~y[0]);

  assign lt = (~x[3] & y[3])
            | (bit_eq[3] & ~x[2] & y[2])
            | (bit_eq[3] & bit_eq[2] & ~x[1] & y[1])
            | (bit_eq[3] & bit_eq[2] & bit_eq[1] & ~x[0] & y[0]);

  assign eq = &bit_eq;
endmodule

module comp4_sort_ctrl #(
  parameter int DEPTH  = 4,
  parameter bit ASCEND = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  comp4_sort_ctrl_if.slave  io,
  output logic              busy,
  output logic [5:0]        swap_cnt
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    mem [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx, idx, pass, idx_p1;
  logic          pass_swapped;

  logic cmp_gt, cmp_eq, cmp_lt, swap_cond;
  logic in_xfer, out_xfer, do_swap, end_pass, sort_done, load_done, drain_done;

  assign idx_p1 = idx + 1'b1;

  comp4bit u_cmp (
    .x  (mem[idx]),
    .y  (mem[idx_p1]),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  // Equal neighbours never swap, which keeps the sort stable.
  assign swap_cond = !cmp_eq && (ASCEND ? cmp_gt : cmp_lt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt    = state;
    in_xfer      = 1'b0;
    out_xfer     = 1'b0;
    do_swap      = 1'b0;
    end_pass     = 1'b0;
    sort_done    = 1'b0;
    load_done    = 1'b0;
    drain_done   = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_data  = '0;
    io.out_last  = 1'b0;
    busy         = 1'b0;

    case (state)
      LOAD: begin
        io.in_ready = 1'b1;
        in_xfer     = io.in_valid;
        load_done   = in_xfer && (wr_idx == LAST);
        if (load_done) state_nxt = SORT;
      end
      SORT: begin
        busy      = 1'b1;
        do_swap   = swap_cond;
        end_pass  = (idx == IDX_LAST);
        // Stop after a clean pass, or once DEPTH-1 passes guarantee order.
        sort_done = end_pass && (!(pass_swapped || do_swap) || (pass == IDX_LAST));
        if (sort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        io.out_valid = 1'b1;
        io.out_data  = mem[rd_idx];
        io.out_last  = (rd_idx == LAST);
        out_xfer     = io.out_ready;
        drain_done   = out_xfer && (rd_idx == LAST);
        if (drain_done) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the word store is reset like any other register because a
      // reset must leave no stale batch contents behind.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      idx          <= '0;
      pass         <= '0;
      pass_swapped <= 1'b0;
      swap_cnt     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_xfer) begin
            mem[wr_idx] <= io.in_data;
            if (wr_idx == '0) swap_cnt <= '0;
            if (load_done) begin
              wr_idx       <= '0;
              idx          <= '0;
              pass         <= '0;
              pass_swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            // NOTE: non-blocking assignments read both old values before
            // either is written, so the pair exchanges without a temporary.
            mem[idx]     <= mem[idx_p1];
            mem[idx_p1]  <= mem[idx];
            pass_swapped <= 1'b1;
            if (swap_cnt != 6'h3f) swap_cnt <= swap_cnt + 6'd1;
          end
          if (!end_pass) begin
            idx <= idx_p1;
          end else if (!sort_done) begin
            pass         <= pass + 1'b1;
            idx          <= '0;
            pass_swapped <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (drain_done) rd_idx <= '0;
            else            rd_idx <= rd_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp4_sort_ctrl.sv
// Self-checking bench: directed and random batches through an ascending and a
// descending sorter, checked against an arithmetic model of bubble sort.
module tb_comp4_sort_ctrl;
  localparam int DEPTH = 4;
  typedef logic [3:0] word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       use_desc;
  logic       iv;
  logic [3:0] id;
  logic       ordy;
  int         checks = 0;
  int         errors = 0;

  comp4_sort_ctrl_if io_a ();
  comp4_sort_ctrl_if io_d ();
  logic       busy_a, busy_d;
  logic [5:0] sc_a, sc_d;

  assign io_a.in_valid  = use_desc ? 1'b0 : iv;
  assign io_a.in_data   = id;
  assign io_a.out_ready = use_desc ? 1'b0 : ordy;
  assign io_d.in_valid  = use_desc ? iv : 1'b0;
  assign io_d.in_data   = id;
  assign io_d.out_ready = use_desc ? ordy : 1'b0;

  comp4_sort_ctrl #(.DEPTH(DEPTH), .ASCEND(1'b1)) dut_a (
    .clk(clk), .rst(rst), .io(io_a), .busy(busy_a), .swap_cnt(sc_a));
  comp4_sort_ctrl #(.DEPTH(DEPTH), .ASCEND(1'b0)) dut_d (
    .clk(clk), .rst(rst), .io(io_d), .busy(busy_d), .swap_cnt(sc_d));

  logic       o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [3:0] o_out_data;
  logic [5:0] o_swap;
  assign o_in_ready  = use_desc ? io_d.in_ready  : io_a.in_ready;
  assign o_out_valid = use_desc ? io_d.out_valid : io_a.out_valid;
  assign o_out_last  = use_desc ? io_d.out_last  : io_a.out_last;
  assign o_out_data  = use_desc ? io_d.out_data  : io_a.out_data;
  assign o_busy      = use_desc ? busy_d : busy_a;
  assign o_swap      = use_desc ? sc_d   : sc_a;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bubble sort swaps each strictly out-of-order pair exactly once.
  function automatic int model_swaps(input word_t w[DEPTH], input bit asc);
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (asc ? (w[i] > w[j]) : (w[i] < w[j])) n++;
    return n;
  endfunction

  // Passes = largest count of out-of-order predecessors, plus one clean pass,
  // capped at DEPTH-1 passes.
  function automatic int model_busy(input word_t w[DEPTH], input bit asc);
    int k = 0;
    int passes;
    for (int j = 0; j < DEPTH; j++) begin
      int c = 0;
      for (int i = 0; i < j; i++)
        if (asc ? (w[i] > w[j]) : (w[i] < w[j])) c++;
      if (c > k) k = c;
    end
    passes = (k == 0) ? 1 : ((k + 1 > DEPTH - 1) ? DEPTH - 1 : k + 1);
    return passes * (DEPTH - 1);
  endfunction

  task automatic model_sorted(input word_t w[DEPTH], input bit asc, output word_t s[DEPTH]);
    word_t q[$];
    for (int i = 0; i < DEPTH; i++) q.push_back(w[i]);
    if (asc) q.sort();
    else     q.rsort();
    for (int i = 0; i < DEPTH; i++) s[i] = q[i];
  endtask

  // NOTE: inputs change and outputs are sampled on the falling edge, away
  // from the rising edge where the DUT registers them.
  task automatic load_batch(input word_t w[DEPTH], input bit stress);
    int  i = 0;
    int  budget = 0;
    logic xfer;
    while (i < DEPTH && budget < 200) begin
      @(negedge clk);
      budget++;
      if (stress && ($urandom_range(0, 2) == 0)) begin
        iv = 1'b0;
        id = 4'bx;
      end else begin
        iv = 1'b1;
        id = w[i];
      end
      check("in_ready_load", o_in_ready, 1'b1);
      xfer = iv && o_in_ready;
      @(posedge clk);
      if (xfer) i++;
    end
    check("load_complete", (i == DEPTH), 1'b1);
    @(negedge clk);
    iv = 1'b0;
    id = 4'bx;
  endtask

  task automatic wait_sort(input int exp_busy, input int exp_swaps);
    int n = 0;
    int budget = 0;
    check("busy_entry", o_busy, 1'b1);
    while (!o_out_valid && budget < 100) begin
      if (o_busy) n++;
      check("in_ready_sort", o_in_ready, 1'b0);
      budget++;
      @(negedge clk);
    end
    check("drain_reached", o_out_valid, 1'b1);
    check("busy_cycles", 8'(n), 8'(exp_busy));
    check("swap_cnt", o_swap, 8'(exp_swaps));
    check("busy_in_drain", o_busy, 1'b0);
  endtask

  task automatic drain_batch(input word_t s[DEPTH], input bit stress);
    int  j = 0;
    int  budget = 0;
    logic xfer;
    while (j < DEPTH && budget < 300) begin
      budget++;
      check("out_valid", o_out_valid, 1'b1);
      if (!o_out_valid) break;
      check("in_ready_drain", o_in_ready, 1'b0);
      check("out_data", o_out_data, s[j]);
      check("out_last", o_out_last, (j == DEPTH - 1));
      ordy = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
      xfer = ordy && o_out_valid;
      @(posedge clk);
      if (xfer) j++;
      @(negedge clk);
    end
    ordy = 1'b0;
    check("drain_count", (j == DEPTH), 1'b1);
    check("out_valid_after", o_out_valid, 1'b0);
    check("in_ready_after", o_in_ready, 1'b1);
    check("out_data_idle", o_out_data, 4'd0);
    check("out_last_idle", o_out_last, 1'b0);
  endtask

  task automatic run_batch(input word_t w[DEPTH], input bit asc, input bit stress);
    word_t s[DEPTH];
    use_desc = !asc;
    model_sorted(w, asc, s);
    load_batch(w, stress);
    wait_sort(model_busy(w, asc), model_swaps(w, asc));
    drain_batch(s, stress);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  o_in_ready,  1'b1);
    check({tag, "_out_valid"}, o_out_valid, 1'b0);
    check({tag, "_out_data"},  o_out_data,  4'd0);
    check({tag, "_out_last"},  o_out_last,  1'b0);
    check({tag, "_busy"},      o_busy,      1'b0);
    check({tag, "_swap_cnt"},  o_swap,      6'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w[DEPTH];
    int    n;

    rst = 1'b1; iv = 1'b0; id = 4'bx; ordy = 1'b0; use_desc = 1'b0;
    #3;
    check_reset_outputs("por_asc");
    use_desc = 1'b1;
    #1;
    check_reset_outputs("por_desc");
    use_desc = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    w = '{4'd3, 4'd1, 4'd7, 4'd0};   run_batch(w, 1'b1, 1'b0);
    w = '{4'd3, 4'd3, 4'd7, 4'd15};  run_batch(w, 1'b1, 1'b0);
    w = '{4'd15, 4'd7, 4'd3, 4'd1};  run_batch(w, 1'b1, 1'b0);
    w = '{4'd15, 4'd7, 4'd3, 4'd1};  run_batch(w, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a drain.
    use_desc = 1'b0;
    w = '{4'd3, 4'd1, 4'd7, 4'd0};
    load_batch(w, 1'b0);
    wait_sort(model_busy(w, 1'b1), model_swaps(w, 1'b1));
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_drain");
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_drain_in_ready", o_in_ready, 1'b1);

    // Reset on the 4th busy cycle of a reversed batch; nothing may leak out.
    w = '{4'd15, 4'd7, 4'd3, 4'd1};
    load_batch(w, 1'b0);
    n = 1;
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    check("midsort_busy", o_busy, 1'b1);
    check("midsort_swaps", o_swap, 6'd3);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_sort");
    #1 rst = 1'b0;
    w = '{4'd2, 4'd0, 4'd1, 4'd3};
    run_batch(w, 1'b1, 1'b0);

    // Random batches with input gaps, X data and output stalls.
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < DEPTH; i++) w[i] = 4'($urandom_range(0, 15));
      run_batch(w, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
